// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive-side monitor for a multiplexed 8-digit 7-segment display bus. It
// samples the scanned digit-select/segment bus and rebuilds the displayed
// digits (value, decimal point, valid). It also flags illegal segment codes,
// reports complete scan frames and signals a stale bus.
//
// A {digit-select, segment} pattern must hold unchanged for STABLE_CYC cycles
// before it is captured. This rejects ghosting while the driver switches
// digits. Exactly one capture happens per stable window.
//
// Parameters
//   STABLE_CYC   cycles the synchronised pattern must hold before a capture
//   TIMEOUT_CYC  cycles without any capture before stale asserts
//
// Ports
//   sys_clk     in   1   system clock, rising edge
//   sys_rst     in   1   synchronous, active-high reset
//   scan_bit    in   8   digit select, active-low, one-hot-low; bit i = digit i
//   segment     in   8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   digit_val   out  32  decoded value of digit i at [4i+3:4i]
//   digit_dp    out  8   decimal point of digit i, 1 = lit
//   digit_vld   out  8   digit i holds a legal captured code
//   frame_done  out  1   pulse: all 8 digits captured since the last pulse
//   code_err    out  1   pulse: an illegal segment code was captured
//   stale       out  1   level: no capture for TIMEOUT_CYC cycles
//
// Configuration macro
//   SEG_HEX_EN  when defined, the hex glyphs A b C d E F decode as 4'hA..4'hF.
//               When undefined, those codes are treated as illegal.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  scan_bit,
  input  logic [7:0]  segment,
  output logic [31:0] digit_val,
  output logic [7:0]  digit_dp,
  output logic [7:0]  digit_vld,
  output logic        frame_done,
  output logic        code_err,
  output logic        stale
);

  localparam int STAB_W = $clog2(STABLE_CYC) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t            state, state_next;
  logic [15:0]       sync1, sync2, pat_prev;
  logic [7:0]        pat_bit, pat_seg;
  logic              changed, one_hot, capture;
  logic [2:0]        cap_idx;
  logic [STAB_W-1:0] stab_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        mask;
  logic [3:0]        dec_val;
  logic              dec_legal, dec_blank;

  // Two-flop synchroniser plus a one-cycle history for change detection.
  // The reset value is the idle bus, all lines high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1    <= '1;
      sync2    <= '1;
      pat_prev <= '1;
    end else begin
      sync1    <= {scan_bit, segment};
      sync2    <= sync1;
      pat_prev <= sync2;
    end
  end

  assign pat_bit = sync2[15:8];
  assign pat_seg = sync2[7:0];
  assign changed = (sync2 != pat_prev);
  assign one_hot = $onehot(~pat_bit);

  // Counts the cycles the pattern has been unchanged. It saturates and
  // restarts on any change.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                stab_cnt <= '0;
    else if (changed)           stab_cnt <= '0;
    else if (stab_cnt != '1)    stab_cnt <= stab_cnt + 1'b1;
  end

  // Index of the low select line. This is meaningful only when one_hot is set.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!pat_bit[i]) cap_idx = 3'(i);
    end
  end

  // Segment decode. The g..a lines are active-low; 7'h7F is a blanked digit.
  always_comb begin
    dec_val   = '0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (pat_seg[6:0])
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
`ifdef SEG_HEX_EN
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
`endif
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (one_hot) state_next = SETTLE;
      SETTLE:  if (!one_hot)    state_next = IDLE;
               else if (capture) state_next = LOCKED;
      LOCKED:  if (!one_hot)    state_next = IDLE;
               else if (changed) state_next = SETTLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: output logic. A capture fires once, when the window has just completed.
  always_comb begin
    capture = (state == SETTLE) && one_hot && !changed && (stab_cnt == STAB_LAST);
  end

  // Digit store, frame tracking and stale timeout. A capture takes priority
  // over the timeout, so a capture that lands on the timeout keeps stale low.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digit_val  <= '0;
      digit_dp   <= '0;
      digit_vld  <= '0;
      frame_done <= 1'b0;
      code_err   <= 1'b0;
      stale      <= 1'b0;
      mask       <= '0;
      to_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      code_err   <= 1'b0;
      if (capture) begin
        to_cnt <= '0;
        stale  <= 1'b0;
        if (dec_legal) begin
          digit_val[{cap_idx, 2'b00} +: 4] <= dec_val;
          digit_dp[cap_idx]                <= ~pat_seg[7];
          digit_vld[cap_idx]               <= 1'b1;
        end else if (dec_blank) begin
          digit_dp[cap_idx]  <= ~pat_seg[7];
          digit_vld[cap_idx] <= 1'b0;
        end else begin
          digit_vld[cap_idx] <= 1'b0;
          code_err           <= 1'b1;
        end
        // A repeated digit leaves the mask unchanged, so it cannot advance the frame.
        if ((mask | ~pat_bit) == 8'hFF) begin
          frame_done <= 1'b1;
          mask       <= '0;
        end else begin
          mask <= mask | ~pat_bit;
        end
      end else if (to_cnt == TO_LAST) begin
        stale     <= 1'b1;
        digit_vld <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
